// File: rtl/pitch_lag_decode.sv
// Pitch lag decoder: turns an 8-bit absolute (subframe 0) or 5-bit relative (subframe 1) pitch index into T0/T0_frac.
// Optional bad_pitch output is enabled by defining PITCH_LAG_BAD_FLAG_EN.
module pitch_lag_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        subframe,
  input  logic [15:0] index,
  input  logic [15:0] parity_sum,
  input  logic        bfi,
  output logic        done,
  output logic [15:0] T0,
  output logic [15:0] T0_frac
`ifdef PITCH_LAG_BAD_FLAG_EN
  ,
  output logic        bad_pitch
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CALC  = 3'd1;
  localparam logic [2:0] S_MULT  = 3'd2;
  localparam logic [2:0] S_FINAL = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [15:0] LAG_MIN = 16'd20;
  localparam logic [15:0] LAG_MAX = 16'd143;

  // 16-bit two's-complement add/sub, saturating at the signed limits
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {a[15], a} + {b[15], b};
    if (s[16] != s[15]) sat_add = s[16] ? 16'h8000 : 16'h7fff;
    else                sat_add = s[15:0];
  endfunction

  function automatic logic [15:0] sat_sub(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {a[15], a} - {b[15], b};
    if (s[16] != s[15]) sat_sub = s[16] ? 16'h8000 : 16'h7fff;
    else                sat_sub = s[15:0];
  endfunction

  logic [2:0]  state;
  logic        sub_r;
  logic        bad_r;
  logic [15:0] idx_r;
  logic [15:0] addend_r;
  logic [15:0] t0_min_r;
  logic [31:0] prod_r;
  logic [15:0] old_t0;

  logic [15:0] t0_min_next;
  logic [15:0] t0_lo;
  logic [15:0] t0_hi;
  logic [15:0] q;
  logic [15:0] i_val;
  logic [15:0] next_t0;
  logic [15:0] next_frac;
  logic [15:0] next_old;
  logic [15:0] three_x;
  logic        unused_bits;

  assign done        = (state == S_DONE);
  assign q           = prod_r[30:15];
  assign unused_bits = ^{index[15:8], parity_sum[15:1], prod_r[31], prod_r[14:0]};

  // Search window for the relative lag, centred on the previous T0 and kept inside [20,143]
  always_comb begin
    t0_lo = sat_sub(T0, 16'd5);
    if ($signed(t0_lo) < $signed(LAG_MIN)) t0_lo = LAG_MIN;
    t0_hi = sat_add(t0_lo, 16'd9);
    if ($signed(t0_hi) > $signed(LAG_MAX)) t0_lo = 16'd134;
    t0_min_next = t0_lo;
  end

  always_comb begin
    next_t0   = T0;
    next_frac = T0_frac;
    next_old  = old_t0;
    i_val     = sat_sub(q, 16'd1);
    three_x   = 16'd0;
    if (bad_r) begin
      next_t0   = old_t0;
      next_frac = 16'd0;
      next_old  = ($signed(old_t0) >= $signed(LAG_MAX)) ? LAG_MAX : sat_add(old_t0, 16'd1);
    end else begin
      if (!sub_r) begin
        if (idx_r >= 16'd197) begin
          next_t0   = sat_sub(idx_r, 16'd112);
          next_frac = 16'd0;
        end else begin
          next_t0   = sat_add(q, 16'd19);
          three_x   = sat_add(next_t0, sat_add(next_t0, next_t0));
          next_frac = sat_add(sat_sub(idx_r, three_x), 16'd58);
        end
      end else begin
        next_t0   = sat_add(i_val, t0_min_r);
        three_x   = sat_add(i_val, sat_add(i_val, i_val));
        next_frac = sat_sub(sat_sub(idx_r, 16'd2), three_x);
      end
      next_old = next_t0;
    end
  end

  // Results and old_T0 are committed only on leaving FINAL, so a reset earlier in the sequence leaves no trace
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      T0       <= 16'd0;
      T0_frac  <= 16'd0;
      old_t0   <= 16'd60;
      bad_r    <= 1'b0;
      sub_r    <= 1'b0;
      idx_r    <= 16'd0;
      addend_r <= 16'd0;
      t0_min_r <= 16'd0;
      prod_r   <= 32'd0;
`ifdef PITCH_LAG_BAD_FLAG_EN
      bad_pitch <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sub_r <= subframe;
            idx_r <= subframe ? {11'd0, index[4:0]} : {8'd0, index[7:0]};
            bad_r <= bfi | (~subframe & parity_sum[0]);
            state <= S_CALC;
          end
        end
        S_CALC: begin
          addend_r <= sat_add(idx_r, 16'd2);
          t0_min_r <= t0_min_next;
          state    <= S_MULT;
        end
        S_MULT: begin
          prod_r <= {16'd0, addend_r} * 32'd10923;
          state  <= S_FINAL;
        end
        S_FINAL: begin
          T0      <= next_t0;
          T0_frac <= next_frac;
          old_t0  <= next_old;
`ifdef PITCH_LAG_BAD_FLAG_EN
          bad_pitch <= bad_r;
`endif
          state   <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pitch_lag_decode.md
PITCH_LAG_DECODE -- requirements
Module: pitch_lag_decode

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-low reset.
REQ-003 SHALL have port: start  input  1  one-cycle request to decode one subframe lag.
REQ-004 SHALL have port: subframe  input  1  0 = first subframe (8-bit absolute index), 1 = second subframe (5-bit relative index).
REQ-005 SHALL have port: index  input  16  pitch index; bits [7:0] used for subframe 0, bits [4:0] for subframe 1, the rest ignored.
REQ-006 SHALL have port: parity_sum  input  16  parity-check result; bit 0 = 1 flags a parity error; used for subframe 0 only.
REQ-007 SHALL have port: bfi  input  1  bad-frame (erasure) indicator.
REQ-008 SHALL have port: done  output  1  one-cycle pulse; T0/T0_frac valid.
REQ-009 SHALL have port: T0  output  16  integer pitch lag, 20..143 when decoded.
REQ-010 SHALL have port: T0_frac  output  16  signed fractional lag, -1, 0 or +1, two's complement.

Function
REQ-011 SHALL sample inputs on the cycle start=1 while in IDLE; start in any other state is ignored.
REQ-012 SHALL use FSM IDLE -> CALC -> MULT -> FINAL -> DONE -> IDLE, one cycle per state; done=1 only in DONE (fixed 4-cycle latency).
REQ-013 SHALL hold T0/T0_frac unchanged between done pulses.
REQ-014 SHALL set bad = bfi | parity_sum[0] for subframe 0, and bad = bfi for subframe 1.
REQ-015 If bad, SHALL output T0=old_T0, T0_frac=0, then update old_T0 = min(old_T0+1, 143).
REQ-016 Subframe 0, good, index<197: q = ((index+2)*10923)>>15 (32-bit product); T0 = q+19; T0_frac = index - 3*T0 + 58.
REQ-017 Subframe 0, good, index>=197: T0 = index-112; T0_frac = 0.
REQ-018 Subframe 1, good: T0_min = max(prevT0-5, 20); T0_max = T0_min+9; if T0_max>143 then T0_max=143, T0_min=134.
REQ-019 Subframe 1, good: i = (((index+2)*10923)>>15) - 1; T0 = i+T0_min; T0_frac = index - 2 - 3*i.
REQ-020 prevT0 SHALL be the T0 output register value, whether concealed or decoded.
REQ-021 On good decode, SHALL set old_T0 = new T0.
REQ-022 All add/sub SHALL be 16-bit two's complement with saturation to [-32768, 32767].
REQ-023 A subframe-1 request without a preceding subframe-0 request SHALL use current T0 register value.

Reset
REQ-024 On clk edge with reset=0: state=IDLE, done=0, T0=0, T0_frac=0, old_T0=60, bad flag=0.
REQ-025 Reset mid-decode SHALL abort without a done pulse and without updating old_T0.

Configuration
REQ-026 With PITCH_LAG_BAD_FLAG_EN defined, SHALL add output bad_pitch (1 bit) = bad of the last completed request, updated in DONE, reset 0.
REQ-027 Without PITCH_LAG_BAD_FLAG_EN, port bad_pitch SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-028 Reset, subframe0, index 0, bfi=0, parity_sum=0 -> done 4 cycles later, T0=19, T0_frac=1; index 100 -> T0=53, T0_frac=0xFFFF; index 200 -> T0=88, T0_frac=0.
REQ-029 After subframe0 T0=53: subframe1 index 17 -> T0=53, frac=0; index 0 -> T0=47, frac=1.
REQ-030 After subframe0 index 0 (T0=19): subframe1 index 31 -> T0=30, frac=0xFFFF (lower clamp, T0_min=20); after subframe0 index 255 (T0=143): subframe1 index 17 -> T0=139, frac=0 (upper clamp).
REQ-031 Reset, subframe0 bfi=1 -> T0=60, frac=0; repeat -> T0=61; subframe0 parity_sum=1 with old_T0=143 -> T0=143, old_T0 stays 143; bad_pitch=1 when enabled.
REQ-032 start re-asserted during CALC is ignored (single done pulse); reset=0 in MULT -> no done, next request with bfi=1 gives T0=60.
